adc_filter_40mhz: RTL and testbench

Produces the 40 MHz compatibility-mode ADC stream for the single-bin 40 MHz trigger from the native 120 MHz samples. Each of the three PMT channels goes through a 5-tap anti-alias FIR with weights 1,2,2,2,1 and a divide-by-8, decimated by 3. The block also generates the ENABLE40 phase count that gates the downstream trigger. It sits directly upstream of the 40 MHz single-bin trigger, which consumes its ENABLE40 and ADC0..ADC2 outputs.

---
 rtl/adc_filter_40mhz.sv | 151 +++++++++++++++
 tb/tb_adc_filter_40mhz.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_filter_40mhz.sv
// adc_filter_40mhz
// Builds the 40 MHz compatibility-mode ADC stream from the native 120 MHz
// PMT samples. Each channel has a 5-tap anti-alias FIR with weights
// 1,2,2,2,1. The sum is divided by 8 and decimated by 3 on the shared
// ENABLE40 phase.
//
// Build option: define ADC_FILTER40_ROUND_EN to round half up
// (bias of 4 before the divide). When it is undefined the result is
// truncated toward zero.
//
// Pipeline:
//   taps  : D0..D4 shift every cycle
//   p1    : A = D0+D4, B = D1+D2+D3 registered every cycle
//   p2    : ADCn = (A + 2B + bias) >> 3, loaded only when ENABLE40 == 2
//
// Sample width is fixed at 12 bits, matching ADC_WIDTH of the trigger
// definitions.

module adc_filter_40mhz (
    input  logic        CLK120,
    input  logic        RESET,
    input  logic        SYNC40,
    input  logic [11:0] ADC0_IN,
    input  logic [11:0] ADC1_IN,
    input  logic [11:0] ADC2_IN,
    output logic [1:0]  ENABLE40,
    output logic [11:0] ADC0,
    output logic [11:0] ADC1,
    output logic [11:0] ADC2
);

    localparam int DATA_W = 12;
    localparam int NCH    = 3;
    localparam int NTAP   = 5;
    localparam int SUMA_W = DATA_W + 1;  // two samples
    localparam int SUMB_W = DATA_W + 2;  // three samples
    localparam int ACC_W  = DATA_W + 3;  // A + 2B + bias, max 32764

    localparam logic [1:0] PHASE_LAST = 2'd2;

`ifdef ADC_FILTER40_ROUND_EN
    localparam logic [ACC_W-1:0] RND_BIAS = ACC_W'(4);
`else
    localparam logic [ACC_W-1:0] RND_BIAS = '0;
`endif

    // Full-scale weighted sum -> 12-bit sample. The sum never exceeds
    // 8*4095+4, so the shifted result always fits and needs no clamp.
    function automatic logic [DATA_W-1:0] scale_out(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] biased;
        biased = acc + RND_BIAS;
        return DATA_W'(biased >> 3);
    endfunction

    // Weighted FIR sum: outer taps (A) at weight 1, inner taps (B) at weight 2.
    function automatic logic [ACC_W-1:0] fir_sum(input logic [SUMA_W-1:0] a,
                                                 input logic [SUMB_W-1:0] b);
        return ACC_W'(a) + (ACC_W'(b) << 1);
    endfunction

    logic [DATA_W-1:0] adc_in    [NCH];

    logic [DATA_W-1:0] tap_d     [NCH][NTAP];
    logic [DATA_W-1:0] tap_q     [NCH][NTAP];

    logic [SUMA_W-1:0] suma_p1_d [NCH];
    logic [SUMA_W-1:0] suma_p1_q [NCH];
    logic [SUMB_W-1:0] sumb_p1_d [NCH];
    logic [SUMB_W-1:0] sumb_p1_q [NCH];

    logic [DATA_W-1:0] adc_p2_d  [NCH];
    logic [DATA_W-1:0] adc_p2_q  [NCH];

    logic [1:0]        phase_d;
    logic [1:0]        phase_q;
    logic              upd_p2;

    assign adc_in[0] = ADC0_IN;
    assign adc_in[1] = ADC1_IN;
    assign adc_in[2] = ADC2_IN;

    // Tap delay line: new sample enters D0, older samples move one tap down.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            tap_d[c][0] = adc_in[c];
            for (int k = 1; k < NTAP; k++) begin
                tap_d[c][k] = tap_q[c][k-1];
            end
        end
    end

    // ---- taps -> p1: partial sums split by FIR weight ----
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            suma_p1_d[c] = SUMA_W'(tap_q[c][0]) + SUMA_W'(tap_q[c][4]);
            sumb_p1_d[c] = SUMB_W'(tap_q[c][1]) + SUMB_W'(tap_q[c][2])
                         + SUMB_W'(tap_q[c][3]);
        end
    end

    // ---- p1 -> p2: decimated output, loaded on the last phase only ----
    always_comb begin
        upd_p2 = (phase_q == PHASE_LAST);
        for (int c = 0; c < NCH; c++) begin
            adc_p2_d[c] = adc_p2_q[c];
            if (upd_p2) begin
                adc_p2_d[c] = scale_out(fir_sum(suma_p1_q[c], sumb_p1_q[c]));
            end
        end
    end

    // Phase counter 0,1,2: SYNC40 realigns to 0 but never suppresses the
    // update already scheduled by phase 2 (that is decided by phase_q).
    always_comb begin
        phase_d = phase_q + 2'd1;
        if (SYNC40 || phase_q >= PHASE_LAST) begin
            phase_d = 2'd0;
        end
    end

    // State registers; RESET clears the whole datapath so outputs ramp from 0.
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            phase_q <= 2'd0;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAP; k++) begin
                    tap_q[c][k] <= '0;
                end
                suma_p1_q[c] <= '0;
                sumb_p1_q[c] <= '0;
                adc_p2_q[c]  <= '0;
            end
        end else begin
            phase_q <= phase_d;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < NTAP; k++) begin
                    tap_q[c][k] <= tap_d[c][k];
                end
                suma_p1_q[c] <= suma_p1_d[c];
                sumb_p1_q[c] <= sumb_p1_d[c];
                adc_p2_q[c]  <= adc_p2_d[c];
            end
        end
    end

    assign ENABLE40 = phase_q;
    assign ADC0     = adc_p2_q[0];
    assign ADC1     = adc_p2_q[1];
    assign ADC2     = adc_p2_q[2];

endmodule

// File: tb/tb_adc_filter_40mhz.sv
// Directed bench for adc_filter_40mhz. Expected values are worked out by
// hand from y[n] = (x[n-2] + 2x[n-3] + 2x[n-4] + 2x[n-5] + x[n-6] + R) >> 3,
// which is the output after update edge n. Edge 1 is the first edge after
// reset release, and updates happen at edges 3, 6, 9, ...

module tb_adc_filter_40mhz;

`ifdef ADC_FILTER40_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        CLK120 = 1'b0;
    logic        RESET  = 1'b1;
    logic        SYNC40 = 1'b0;
    logic [11:0] ADC0_IN = '0;
    logic [11:0] ADC1_IN = '0;
    logic [11:0] ADC2_IN = '0;
    logic [1:0]  ENABLE40;
    logic [11:0] ADC0;
    logic [11:0] ADC1;
    logic [11:0] ADC2;

    int n_vec = 0;
    int n_err = 0;

    adc_filter_40mhz dut (
        .CLK120   (CLK120),
        .RESET    (RESET),
        .SYNC40   (SYNC40),
        .ADC0_IN  (ADC0_IN),
        .ADC1_IN  (ADC1_IN),
        .ADC2_IN  (ADC2_IN),
        .ENABLE40 (ENABLE40),
        .ADC0     (ADC0),
        .ADC1     (ADC1),
        .ADC2     (ADC2)
    );

    always #5 CLK120 = ~CLK120;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK120);
        #1;
    endtask

    task automatic do_reset();
        RESET  = 1'b1;
        SYNC40 = 1'b0;
        repeat (3) tick();
        RESET  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int ex0 [9];
        int ex2 [9];

        // Reset with nonzero inputs, then DC release.
        ADC0_IN = 12'd500;
        ADC1_IN = 12'd600;
        ADC2_IN = 12'd700;
        RESET   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_en",   int'(ENABLE40), 0);
            check("rst_adc0", int'(ADC0), 0);
            check("rst_adc1", int'(ADC1), 0);
            check("rst_adc2", int'(ADC2), 0);
        end
        RESET   = 1'b0;
        ADC0_IN = 12'd1000;
        ADC1_IN = 12'd0;
        ADC2_IN = 12'd4095;
        ex0 = '{0, 0, 125, 125, 125, 875, 875, 875, 1000};
        ex2 = '{0, 0, RND ? 512 : 511, RND ? 512 : 511, RND ? 512 : 511,
                3583, 3583, 3583, 4095};
        for (int n = 1; n <= 9; n++) begin
            tick();
            check("dc_en",   int'(ENABLE40), n % 3);
            check("dc_adc0", int'(ADC0), ex0[n-1]);
            check("dc_adc1", int'(ADC1), 0);
            check("dc_adc2", int'(ADC2), ex2[n-1]);
        end

        // Rounding: a 105 among 100s at weight 1, then at weight 2.
        do_reset();
        ADC1_IN = 12'd0;
        for (int n = 1; n <= 18; n++) begin
            ADC0_IN = (n == 10) ? 12'd105 : 12'd100;
            ADC2_IN = (n == 13) ? 12'd105 : 12'd100;
            tick();
            if (n == 9) begin
                check("rnd_adc0_9", int'(ADC0), 100);
                check("rnd_adc2_9", int'(ADC2), 100);
            end
            if (n == 12) begin
                check("rnd_adc0_w1", int'(ADC0), RND ? 101 : 100);
                check("rnd_adc2_12", int'(ADC2), 100);
            end
            if (n == 15) begin
                check("rnd_adc0_w2", int'(ADC0), 101);
                check("rnd_adc2_w1", int'(ADC2), RND ? 101 : 100);
            end
            if (n == 18) begin
                check("rnd_adc0_18", int'(ADC0), 100);
                check("rnd_adc2_w2", int'(ADC2), 101);
            end
        end

        // Step on ADC1, impulse on ADC0.
        do_reset();
        ADC2_IN = 12'd0;
        for (int n = 1; n <= 15; n++) begin
            ADC1_IN = (n >= 7) ? 12'd800 : 12'd0;
            ADC0_IN = (n == 7) ? 12'd800 : 12'd0;
            tick();
            if (n == 6) begin
                check("step_6",  int'(ADC1), 0);
                check("imp_6",   int'(ADC0), 0);
            end
            if (n == 9) begin
                check("step_9",  int'(ADC1), 100);
                check("imp_9",   int'(ADC0), 100);
            end
            if (n == 12) begin
                check("step_12", int'(ADC1), 700);
                check("imp_12",  int'(ADC0), 200);
            end
            if (n == 15) begin
                check("step_15", int'(ADC1), 800);
                check("imp_15",  int'(ADC0), 0);
            end
        end

        // SYNC40 at phase 1 (period cut short) and at phase 2 (update kept).
        do_reset();
        ADC0_IN = 12'd1000;
        ADC1_IN = 12'd0;
        ADC2_IN = 12'd0;
        repeat (9) tick();
        check("sync_pre_en",  int'(ENABLE40), 0);
        check("sync_pre_adc", int'(ADC0), 1000);
        ADC0_IN = 12'd2000;
        tick();                                   // edge 10
        check("sync_e10_en", int'(ENABLE40), 1);
        SYNC40 = 1'b1;
        tick();                                   // edge 11, sync at phase 1
        SYNC40 = 1'b0;
        check("sync_p1_en",  int'(ENABLE40), 0);
        check("sync_p1_adc", int'(ADC0), 1000);
        tick();                                   // edge 12
        check("sync_e12_en",  int'(ENABLE40), 1);
        check("sync_e12_adc", int'(ADC0), 1000);
        tick();                                   // edge 13
        check("sync_e13_en",  int'(ENABLE40), 2);
        check("sync_e13_adc", int'(ADC0), 1000);
        tick();                                   // edge 14, first update after sync
        check("sync_e14_en",  int'(ENABLE40), 0);
        check("sync_e14_adc", int'(ADC0), 1625);
        tick();                                   // edge 15
        tick();                                   // edge 16
        check("sync_e16_en", int'(ENABLE40), 2);
        SYNC40 = 1'b1;
        tick();                                   // edge 17, sync at phase 2
        SYNC40 = 1'b0;
        check("sync_p2_en",  int'(ENABLE40), 0);
        check("sync_p2_adc", int'(ADC0), 2000);
        tick();                                   // edge 18
        check("sync_e18_en", int'(ENABLE40), 1);

        // RESET together with SYNC40 mid-stream.
        RESET  = 1'b1;
        SYNC40 = 1'b1;
        tick();
        check("rs_en",   int'(ENABLE40), 0);
        check("rs_adc0", int'(ADC0), 0);
        RESET  = 1'b0;
        SYNC40 = 1'b0;
        tick();
        check("rs_rel_en",   int'(ENABLE40), 1);
        check("rs_rel_adc0", int'(ADC0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
